multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the CPU core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the datapath mux selects, register/memory strobes and the 3-bit ALUop consumed by the ALU control decoder. Stalls on a single-bit memory ready handshake and flags unsupported opcodes and funct codes.

## Interface
- No parameters; opcode and funct encodings are fixed below.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH completes
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- ALUop  out  3  000 add, 001 sub, 010 addi, 011 subi, 100 R-type (funct decode)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (ANDed in datapath)
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target, 11 = rs
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal_op  out  1  one-cycle pulse on an unsupported instruction
- state  out  4  current state (debug)
- cycle_count, instr_count  out  32 each  present only with MC_PERF_CNT_EN

## Operation
- Opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - addi: 001000
  - subi: 001001
- Legal R-type funct values: 100000 add, 100010 sub, 100110 xor, 001000 jr.
- Per-state outputs (every output not listed is 0):
  - FETCH (0): mem_read=1, alu_src_b=01, ALUop=000. When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, go to DECODE. Otherwise stay.
  - DECODE (1): alu_src_b=11, ALUop=000 (branch target precompute). Next state by opcode: lw/sw→MEM_ADDR, R-type→EXECUTE (funct 001000→JR), beq→BRANCH, j→JUMP, addi/subi→IMM_EXEC.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, ALUop=000. Next: lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ (3): mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
  - MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEM_WRITE (5): mem_write=1, i_or_d=1. Go to FETCH on mem_ready.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, ALUop=100. Go to R_WB.
  - R_WB (7): reg_write=1, reg_dst=1, ALUop=100. Go to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, ALUop=001, pc_write_cond=1, pc_source=01. Go to FETCH.
  - JUMP (9): pc_write=1, pc_source=10. Go to FETCH.
  - IMM_EXEC (10): alu_src_a=1, alu_src_b=10, ALUop=010 (addi) or 011 (subi). Go to IMM_WB.
  - IMM_WB (11): reg_write=1, reg_dst=0, ALUop held from IMM_EXEC. Go to FETCH.
  - JR (12): pc_write=1, pc_source=11. Go to FETCH.
- Illegal instruction: unknown opcode, or R-type with a funct outside the legal set. In DECODE this asserts illegal_op for one cycle and goes to FETCH; no register, memory or PC write occurs.
- Unused encodings 13–15: all outputs 0, next state FETCH.

## Timing
- The state register is the only sequential element (plus the optional counters).
- Outputs decode combinationally from state. ir_write and pc_write in FETCH also depend on mem_ready.
- Reset: state=FETCH asynchronously. While reset_n=0, every output is forced to 0. On the first edge after release, FETCH outputs apply.
- Cycle counts with mem_ready=1 on the first request:
  - lw: 5
  - sw, R-type, addi, subi: 4
  - beq, j, jr: 3
  - illegal: 2
- Each cycle with mem_ready=0 during FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs are held stable while stalled.
- mem_ready is ignored in every other state.
- Reset asserted mid-instruction aborts it immediately; no partial write-back.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_count increments every clock after reset release.
  - instr_count increments on each transition from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, IMM_WB or JR to FETCH. Illegal instructions are not counted.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- MC_PERF_CNT_EN undefined: both counter ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset with mem_ready=1, release → state=0, mem_read=1, alu_src_b=01; next edge: ir_write=pc_write=1, state=1.
- lw (100011) with mem_ready held 0 for 3 cycles in MEM_READ → 8 cycles total; reg_write=1 with mem_to_reg=1 only in MEM_WB.
- R-type funct 100010 → ALUop=100 in states 6–7, reg_dst=1; funct 001000 → JR, pc_source=11, pc_write=1.
- subi (001001) → ALUop=011 in IMM_EXEC and IMM_WB; addi → 010.
- Opcode 111111 or R-type funct 100100 → illegal_op pulses once in DECODE, no write strobe, back to FETCH; with MC_PERF_CNT_EN, instr_count unchanged.
- reset_n pulled low during MEM_WRITE with mem_ready=0 → mem_write=0 immediately, state=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives datapath selects and strobes. Optional perf counters: MC_PERF_CNT_EN.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic [2:0]  ALUop,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic [3:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADDI = 3'b010;
  localparam logic [2:0] ALU_SUBI = 3'b011;
  localparam logic [2:0] ALU_RTYP = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JR        = 4'd12
  } state_t;

  state_t state_q, state_d;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_subi;
  logic legal_fn, illegal;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);
  assign is_subi = (opcode == OP_SUBI);

  assign legal_fn = (funct == FN_ADD) || (funct == FN_SUB) ||
                    (funct == FN_XOR) || (funct == FN_JR);
  assign illegal  = !(is_r || is_lw || is_sw || is_beq || is_j || is_addi || is_subi) ||
                    (is_r && !legal_fn);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Every output stays 0 while reset is held, independent of the state register.
  always_comb begin
    ALUop         = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    state         = 4'd0;
    state_d       = S_FETCH;
    if (reset_n) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_FETCH;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (illegal)                 illegal_op = 1'b1;
          else if (is_lw || is_sw)     state_d = S_MEM_ADDR;
          else if (is_r)               state_d = (funct == FN_JR) ? S_JR : S_EXECUTE;
          else if (is_beq)             state_d = S_BRANCH;
          else if (is_j)               state_d = S_JUMP;
          else                         state_d = S_IMM_EXEC;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = is_lw ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          ALUop     = ALU_RTYP;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          ALUop     = ALU_RTYP;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALUop         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        // opcode is stable through write-back, so IMM_WB re-derives the same ALUop.
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ALUop     = is_subi ? ALU_SUBI : ALU_ADDI;
          state_d   = S_IMM_WB;
        end
        S_IMM_WB: begin
          reg_write = 1'b1;
          ALUop     = is_subi ? ALU_SUBI : ALU_ADDI;
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;
  logic        retire;

  // An instruction retires when a completing state hands back to FETCH.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH,
                                   S_JUMP, S_IMM_WB, S_JR});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, mid-instruction
// reset, and randomized instructions/stalls against a per-instruction path model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic [2:0]  ALUop;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, pc_write_cond;
  logic [1:0]  pc_source;
  logic        i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
`ifdef MC_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         fst;
    int         mst;
    int         cyc;
  } vec_t;

  outs_t dut_o;
  assign dut_o = {ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source, i_or_d,
                  mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op, state};

  int  checks = 0;
  int  errors = 0;
  bit  synced = 0;
  int  seq[$];
  int  n_instr = 0;
  int  cyc_m = 0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc_m <= 0;
    else          cyc_m <= cyc_m + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ill(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return !(fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100110 || fn == 6'b001000);
      6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001001: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Path of an instruction through the numbered states, ignoring stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    seq = '{0, 1};
    if (!is_ill(op, fn)) begin
      case (op)
        6'b100011: seq = '{0, 1, 2, 3, 4};
        6'b101011: seq = '{0, 1, 2, 5};
        6'b000000: seq = (fn == 6'b001000) ? '{0, 1, 12} : '{0, 1, 6, 7};
        6'b000100: seq = '{0, 1, 8};
        6'b000010: seq = '{0, 1, 9};
        default:   seq = '{0, 1, 10, 11};
      endcase
    end
  endtask

  function automatic outs_t exp_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                    input logic mr);
    outs_t o;
    o = '0;
    o.st = 4'(s);
    case (s)
      0:  begin o.mrd = 1; o.src_b = 2'b01; if (mr) begin o.irw = 1; o.pcw = 1; end end
      1:  begin o.src_b = 2'b11; o.ill = is_ill(op, fn); end
      2:  begin o.src_a = 1; o.src_b = 2'b10; end
      3:  begin o.mrd = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mwr = 1; o.iord = 1; end
      6:  begin o.src_a = 1; o.aluop = 3'b100; end
      7:  begin o.rw = 1; o.rdst = 1; o.aluop = 3'b100; end
      8:  begin o.src_a = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcs = 2'b01; end
      9:  begin o.pcw = 1; o.pcs = 2'b10; end
      10: begin o.src_a = 1; o.src_b = 2'b10; o.aluop = (op == 6'b001001) ? 3'b011 : 3'b010; end
      11: begin o.rw = 1; o.aluop = (op == 6'b001001) ? 3'b011 : 3'b010; end
      12: begin o.pcw = 1; o.pcs = 2'b11; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Runs one instruction; cycle count ends when the DUT re-enters FETCH after DECODE.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fst, input int mst, input bit rnd, output int cyc);
    int  idx, fs, ms, guard, s;
    bit  seen;
    logic mr;
    idx = 0; fs = fst; ms = mst; guard = 0; seen = 0; cyc = 0;
    build(op, fn);
    forever begin
      if (!synced) @(negedge clk);
      synced = 0;
      #1;
      if (seen && state == 4'd0) begin synced = 1; break; end
      if (guard >= 64) begin
        chk({name, "_timeout"}, 32'(state), 32'd0);
        break;
      end
      guard++;
      if (state == 4'd1) seen = 1;
      s = (idx < seq.size()) ? seq[idx] : 0;
      opcode = op; funct = fn;
      if (rnd)                                     mr = ($urandom_range(0, 3) != 0);
      else if (s == 0 && fs > 0)                   begin mr = 0; fs--; end
      else if ((s == 3 || s == 5) && ms > 0)       begin mr = 0; ms--; end
      else                                         mr = 1;
      mem_ready = mr;
      #1;
      chk({name, "_outs"}, 32'(dut_o), 32'(exp_out(s, op, fn, mr)));
      cyc++;
      if (!((s == 0 || s == 3 || s == 5) && !mr)) idx++;
    end
    if (!is_ill(op, fn)) n_instr++;
`ifdef MC_PERF_CNT_EN
    chk({name, "_icount"}, instr_count, 32'(n_instr));
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];
  logic [5:0] ops[9];

  initial begin
    int cyc;
    tbl[0]  = '{"lw",        6'b100011, 6'b000000, 0, 0, 5};
    tbl[1]  = '{"lw_stall3", 6'b100011, 6'b010101, 0, 3, 8};
    tbl[2]  = '{"sw",        6'b101011, 6'b000000, 0, 0, 4};
    tbl[3]  = '{"sw_stalls", 6'b101011, 6'b000000, 2, 1, 7};
    tbl[4]  = '{"r_add",     6'b000000, 6'b100000, 0, 0, 4};
    tbl[5]  = '{"r_sub",     6'b000000, 6'b100010, 0, 0, 4};
    tbl[6]  = '{"r_xor",     6'b000000, 6'b100110, 1, 0, 5};
    tbl[7]  = '{"jr",        6'b000000, 6'b001000, 0, 0, 3};
    tbl[8]  = '{"beq",       6'b000100, 6'b000000, 0, 0, 3};
    tbl[9]  = '{"j",         6'b000010, 6'b111111, 0, 0, 3};
    tbl[10] = '{"addi",      6'b001000, 6'b000000, 0, 0, 4};
    tbl[11] = '{"subi",      6'b001001, 6'b000000, 1, 0, 5};
    tbl[12] = '{"ill_op",    6'b111111, 6'b100000, 0, 0, 2};
    tbl[13] = '{"ill_fn",    6'b000000, 6'b100100, 0, 0, 2};
    tbl[14] = '{"ill_op_st", 6'b000001, 6'b000000, 2, 0, 4};
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001001, 6'b111111, 6'b000000};

    // Reset: all outputs low regardless of inputs.
    reset_n = 0; mem_ready = 1; opcode = 6'b100011;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 32'(dut_o), 32'd0);
    mem_ready = 0;
    #1 chk("reset_outs_mr0", 32'(dut_o), 32'd0);
    @(negedge clk);
    mem_ready = 1;
    reset_n = 1;
    synced = 1;
    n_instr = 0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].fst, tbl[i].mst, 1'b0, cyc);
      chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
    end

    // Reset during a stalled store: write strobe drops at once, no completion.
    if (!synced) @(negedge clk);
    synced = 0;
    opcode = 6'b101011; funct = 6'd0; mem_ready = 1;
    #1 chk("abort_fetch_state", 32'(state), 32'd0);
    @(negedge clk); #1 chk("abort_decode_state", 32'(state), 32'd1);
    @(negedge clk); #1 chk("abort_addr_state", 32'(state), 32'd2);
    @(negedge clk); mem_ready = 0;
    #1 chk("abort_memw", 32'({state, mem_write}), 32'({4'd5, 1'b1}));
    @(negedge clk);
    #1 chk("abort_stall_hold", 32'(dut_o), 32'(exp_out(5, 6'b101011, 6'd0, 1'b0)));
    reset_n = 0;
    #1 chk("abort_outs", 32'(dut_o), 32'd0);
    @(posedge clk);
    #1 chk("abort_state_in_reset", 32'(state), 32'd0);
    n_instr = 0;
    @(negedge clk);
    reset_n = 1; mem_ready = 1;
    synced = 1;
    run_instr("post_abort_addi", 6'b001000, 6'd0, 0, 0, 1'b0, cyc);
    chk("post_abort_cycles", 32'(cyc), 32'd4);

    // Random instructions and memory handshakes.
    for (int k = 0; k < 120; k++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100110;
        3: fn = 6'b001000;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      run_instr("rand", op, fn, 0, 0, 1'b1, cyc);
    end

`ifdef MC_PERF_CNT_EN
    if (!synced) @(negedge clk);
    synced = 0;
    #1 chk("cycle_count", cycle_count, 32'(cyc_m));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
